// File: rtl/cond_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg
//
// Shared definitions for the execute-stage conditional logic.
//   cond_t          : the 4-bit ARM condition field, one name per encoding
//   FLAG_N..FLAG_V  : bit positions of N, Z, C, V inside a 4-bit NZCV word
//   nzcv_merge()    : merges a new NZCV word into an old one under a 2-bit
//                     write mask ([1] selects N,Z; [0] selects C,V)
// ---------------------------------------------------------------------------
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bits whose mask bit is clear keep their old value.
  function automatic logic [3:0] nzcv_merge(input logic [3:0] old_nzcv,
                                            input logic [3:0] new_nzcv,
                                            input logic [1:0] write_mask);
    logic [3:0] merged;
    merged = old_nzcv;
    if (write_mask[1]) begin
      merged[FLAG_N] = new_nzcv[FLAG_N];
      merged[FLAG_Z] = new_nzcv[FLAG_Z];
    end
    if (write_mask[0]) begin
      merged[FLAG_C] = new_nzcv[FLAG_C];
      merged[FLAG_V] = new_nzcv[FLAG_V];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ---------------------------------------------------------------------------
// cond_check
//
// Purely combinational ARM condition-code evaluator.
// Ports:
//   cond  in  cond_t       condition field of the instruction
//   nzcv  in  logic [3:0]  flags to evaluate against, {N,Z,C,V}
//   pass  out logic        1 when the instruction should execute
// Both AL (1110) and the 1111 encoding evaluate true.
// ---------------------------------------------------------------------------
module cond_check
  import cond_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = nzcv[FLAG_N];
  assign w_z = nzcv[FLAG_Z];
  assign w_c = nzcv[FLAG_C];
  assign w_v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_cond_stage.sv
// ---------------------------------------------------------------------------
// exec_cond_stage
//
// Execute-stage conditional unit. Evaluates the condition field, gates the
// side-effecting control bits, owns the architected NZCV register and
// registers the surviving control into EX/MEM.
//
// Configuration macro: COND_FLAG_BYPASS_EN
//   defined   : condition evaluated against the internal flags register
//               (flags_e is accepted but ignored)
//   undefined : condition evaluated against the pipelined flags_e
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   en                pipeline advance (0 = hold E and M)
//   flush_e           kill the instruction in E
//   pcsrc_e, regwrite_e, memtoreg_e, memwrite_e, branch_e  ID/EX control
//   flagwrite_e[1:0]  [1] writes N,Z; [0] writes C,V
//   cond_e[3:0]       condition field
//   flags_e[3:0]      NZCV sampled in decode
//   alu_flags[3:0]    NZCV produced by the ALU this cycle
//   cond_ex_e         condition passed and not flushed (combinational)
//   branch_taken_e    redirect to fetch (combinational)
//   flags[3:0]        architected flags, fed back to decode
//   pcsrc_m, regwrite_m, memtoreg_m, memwrite_m  EX/MEM registered control
// ---------------------------------------------------------------------------
module exec_cond_stage
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush_e,
  input  logic       pcsrc_e,
  input  logic       regwrite_e,
  input  logic       memtoreg_e,
  input  logic       memwrite_e,
  input  logic       branch_e,
  input  logic [1:0] flagwrite_e,
  input  logic [3:0] cond_e,
  input  logic [3:0] flags_e,
  input  logic [3:0] alu_flags,
  output logic       cond_ex_e,
  output logic       branch_taken_e,
  output logic [3:0] flags,
  output logic       pcsrc_m,
  output logic       regwrite_m,
  output logic       memtoreg_m,
  output logic       memwrite_m
);

  logic [3:0] r_flags;
  logic       r_pcsrc_m;
  logic       r_regwrite_m;
  logic       r_memtoreg_m;
  logic       r_memwrite_m;

  logic [3:0] w_eval_flags;
  logic       w_cond_pass;
  logic       w_pcsrc_g;
  logic       w_regwrite_g;
  logic       w_memwrite_g;
  logic       w_flag_we;
  logic [3:0] w_flags_next;

  // Flag source for the condition check. With the bypass the instruction
  // directly behind a flag-setter sees the freshly written flags.
`ifdef COND_FLAG_BYPASS_EN
  logic w_unused_flags_e;
  assign w_unused_flags_e = ^flags_e;
  assign w_eval_flags     = r_flags;
`else
  assign w_eval_flags     = flags_e;
`endif

  cond_check u_cond_check (
    .cond (cond_t'(cond_e)),
    .nzcv (w_eval_flags),
    .pass (w_cond_pass)
  );

  assign cond_ex_e      = w_cond_pass & ~flush_e;
  assign branch_taken_e = (branch_e | pcsrc_e) & cond_ex_e;

  assign w_pcsrc_g    = pcsrc_e    & cond_ex_e;
  assign w_regwrite_g = regwrite_e & cond_ex_e;
  assign w_memwrite_g = memwrite_e & cond_ex_e;

  // Writing only while en=1 stops a stalled flag-setter from re-evaluating
  // its condition against its own result on the following cycles.
  assign w_flag_we    = en & cond_ex_e;
  assign w_flags_next = nzcv_merge(r_flags, alu_flags, flagwrite_e);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_we) begin
      r_flags <= w_flags_next;
    end
  end

  // EX/MEM control register: reset > flush > advance > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (flush_e) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (en) begin
      r_pcsrc_m    <= w_pcsrc_g;
      r_regwrite_m <= w_regwrite_g;
      r_memtoreg_m <= memtoreg_e;
      r_memwrite_m <= w_memwrite_g;
    end
  end

  assign flags      = r_flags;
  assign pcsrc_m    = r_pcsrc_m;
  assign regwrite_m = r_regwrite_m;
  assign memtoreg_m = r_memtoreg_m;
  assign memwrite_m = r_memwrite_m;

endmodule

// File: doc/exec_cond_stage.md
# exec_cond_stage

Execute-stage conditional unit of the pipelined ARM core. Sits directly downstream of the ID/EX control register. It evaluates the instruction's condition field against the NZCV flags, gates the side-effecting control signals, owns the architected flags register, and registers the surviving control bits into the EX/MEM stage. It also returns the current flags to decode and the taken-branch redirect to fetch.

## Interface
Parameters:
- none (flag order fixed as {N,Z,C,V} = bits [3:0])

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  pipeline advance; low = stall E and M (hold)
- flush_e  in  1  kill instruction currently in E
- pcsrc_e, regwrite_e, memtoreg_e, memwrite_e, branch_e  in  1 each  control from ID/EX
- flagwrite_e  in  2  [1] updates N,Z; [0] updates C,V
- cond_e  in  4  ARM condition field
- flags_e  in  4  NZCV sampled in decode, pipelined
- alu_flags  in  4  NZCV produced by the ALU this cycle
- cond_ex_e  out  1  condition passed (combinational)
- branch_taken_e  out  1  (branch_e | pcsrc_e) & cond_ex_e, gated by flush_e (combinational)
- flags  out  4  architected flags register, fed back to decode
- pcsrc_m, regwrite_m, memtoreg_m, memwrite_m  out  1 each  registered gated control

## Operation
- Condition codes:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C
  - MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 and 1111 both evaluate true.
- Evaluation flags: flags_e, or the internal register under COND_FLAG_BYPASS_EN (see Configuration).
- cond_ex_e = condition result & !flush_e.
- Gated control:
  - pcsrc_g = pcsrc_e & cond_ex_e
  - regwrite_g = regwrite_e & cond_ex_e
  - memwrite_g = memwrite_e & cond_ex_e
  - memtoreg passes ungated
- Flag update, at posedge when en & cond_ex_e & !reset:
  - flagwrite_e[1] loads flags[3:2] from alu_flags[3:2]
  - flagwrite_e[0] loads flags[1:0] from alu_flags[1:0]
  - Bits not selected hold their value.
- EX/MEM register priority, highest first:
  1. reset: all *_m = 0, flags = 0000
  2. flush_e: all *_m = 0, regardless of en
  3. en: capture the gated control
  4. otherwise hold
- No flag write occurs while en=0. This prevents a stalled flag-setting instruction from re-evaluating against its own result.

## Timing
- Reset values: flags = 0000; pcsrc_m, regwrite_m, memtoreg_m, memwrite_m = 0.
- cond_ex_e and branch_taken_e are combinational from the current inputs, with zero latency.
- Gated control appears on *_m one cycle after the E cycle in which en=1.
- A flag update is visible on flags the cycle after the writing instruction leaves E.
- Back-to-back case: a flag-setter in E at cycle t, followed by a dependent conditional in E at t+1.
  - With bypass: the dependent instruction sees the new flags.
  - Without bypass: it sees the stale flags_e. Upstream must then stall or forward.
- flush_e and en=0 together: M clears, flags hold.
- reset asserted mid-stall clears everything at that edge.

## Configuration
- COND_FLAG_BYPASS_EN defined: the condition is evaluated against the internal flags register. flags_e is ignored, apart from being kept as an unused port.
- COND_FLAG_BYPASS_EN undefined: the condition is evaluated against flags_e exactly as pipelined.
- Both builds have identical ports.

## Structure
- Package cond_pkg:
  - cond_t enum, 4-bit, holding the 16 codes above
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module cond_check: purely combinational, taking (cond_t cond, logic [3:0] nzcv) and returning logic pass.
- Top holds:
  - the flags register
  - the gating logic
  - the EX/MEM control register

## Test plan
- Reset: assert reset with flags previously 1111 and all inputs high -> flags=0000, all *_m=0 after the edge.
- Gating: flags 0100 (Z=1), cond=NE, regwrite_e=memwrite_e=1, en=1 -> cond_ex_e=0, regwrite_m=memwrite_m=0. Repeat with cond=EQ -> both 1.
- Partial flag write: flags=0000, flagwrite_e=10, alu_flags=1111, cond=AL -> flags=1100. Then flagwrite_e=01 -> flags=1111.
- Stall: en=0, cond=NE, flagwrite_e=11, alu_flags=0100 for 3 cycles -> flags unchanged, *_m hold. Then en=1 -> flags=0100 exactly once.
- Flush: flush_e=1, branch_e=1, cond=AL, en=0 -> branch_taken_e=0, *_m=0 next cycle, flags unchanged.
- Bypass (macro on): writer sets Z=1 at t; at t+1 cond=EQ with flags_e=0000 -> cond_ex_e=1. With the macro off -> cond_ex_e=0.
